// File: rtl/gf_pkg.sv
// Shared types and constants for the GF(p) binary-extended-Euclid divider.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } gf_state_t;

    localparam int GF_WIDTH_DEFAULT = 256;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage

// File: rtl/gf_half_mod.sv
// Combinational modular halving: y = x/2 mod p for odd p and x < p.
module gf_half_mod
    import gf_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] y
);

    // An odd x is made even by adding the odd modulus; one extra bit keeps the carry.
    logic [WIDTH:0] sum;

    assign sum = {1'b0, x} + {1'b0, p};
    assign y   = x[0] ? WIDTH'(sum >> 1) : (x >> 1);

endmodule

// File: rtl/gf_div_gen.sv
// Modular divider/inverter over GF(p) using the binary extended Euclidean algorithm.
// Define GF_DIV_CT_EN for constant-time operation (done always MAX_STEPS+2 cycles after start).
module gf_div_gen
    import gf_pkg::*;
#(
    parameter int WIDTH     = GF_WIDTH_DEFAULT,
    parameter int MAX_STEPS = 4 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_select,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_div,
    output logic             busy,
    output logic             done,
    output logic             div_err
);

    localparam int CNT_W = $clog2(MAX_STEPS + 1);

    gf_state_t        state, state_d;
    logic [WIDTH-1:0] u, v, x1, x2, m;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] u_n, v_n, x1_n, x2_n;
    logic [WIDTH-1:0] x1_half, x2_half, hit_val;
    logic             hit, cnt_max, run_exit;
`ifdef GF_DIV_CT_EN
    logic             term;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
`endif

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] mod);
        logic signed [WIDTH:0] d;
        d = signed'({1'b0, x}) - signed'({1'b0, y});
        if (d < 0)
            d = d + signed'({1'b0, mod});
        return d[WIDTH-1:0];
    endfunction

    gf_half_mod #(.WIDTH(WIDTH)) u_half_x1 (.x(x1), .p(m), .y(x1_half));
    gf_half_mod #(.WIDTH(WIDTH)) u_half_x2 (.x(x2), .p(m), .y(x2_half));

    assign hit     = (u == WIDTH'(1)) || (v == WIDTH'(1));
    assign hit_val = (u == WIDTH'(1)) ? x1 : x2;
    assign cnt_max = (cnt == CNT_W'(MAX_STEPS));
`ifdef GF_DIV_CT_EN
    assign run_exit = cnt_max;
`else
    assign run_exit = hit || cnt_max;
`endif

    // One Euclid step; invariants x1*b == u*a and x2*b == v*a (mod p).
    always_comb begin
        u_n  = u;
        v_n  = v;
        x1_n = x1;
        x2_n = x2;
        if (!u[0]) begin
            u_n  = u >> 1;
            x1_n = x1_half;
        end else if (!v[0]) begin
            v_n  = v >> 1;
            x2_n = x2_half;
        end else if (u >= v) begin
            u_n  = u - v;
            x1_n = sub_mod(x1, x2, m);
        end else begin
            v_n  = v - u;
            x2_n = sub_mod(x2, x1, m);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef GF_DIV_CT_EN
                    state_d = RUN;
`else
                    state_d = (b == '0) ? FIN : RUN;
`endif
                end
            end
            RUN: begin
                busy = 1'b1;
                if (run_exit)
                    state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u          <= '0;
            v          <= '0;
            x1         <= '0;
            x2         <= '0;
            m          <= '0;
            cnt        <= '0;
            result_div <= '0;
            div_err    <= 1'b0;
`ifdef GF_DIV_CT_EN
            term       <= 1'b0;
            res_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        u   <= b;
                        v   <= p;
                        m   <= p;
                        x1  <= mode_select ? WIDTH'(1) : a;
                        x2  <= '0;
                        cnt <= '0;
`ifdef GF_DIV_CT_EN
                        term  <= (b == '0);
                        res_q <= '0;
                        err_q <= (b == '0);
`else
                        if (b == '0) begin
                            result_div <= '0;
                            div_err    <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
`ifdef GF_DIV_CT_EN
                    // After termination the loop state is frozen; only the counter advances.
                    if (cnt_max) begin
                        if (term) begin
                            result_div <= res_q;
                            div_err    <= err_q;
                        end else if (hit) begin
                            result_div <= hit_val;
                            div_err    <= 1'b0;
                        end else begin
                            result_div <= '0;
                            div_err    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (!term) begin
                            if (hit) begin
                                term  <= 1'b1;
                                res_q <= hit_val;
                                err_q <= 1'b0;
                            end else begin
                                u  <= u_n;
                                v  <= v_n;
                                x1 <= x1_n;
                                x2 <= x2_n;
                            end
                        end
                    end
`else
                    if (hit) begin
                        result_div <= hit_val;
                        div_err    <= 1'b0;
                    end else if (cnt_max) begin
                        result_div <= '0;
                        div_err    <= 1'b1;
                    end else begin
                        u   <= u_n;
                        v   <= v_n;
                        x1  <= x1_n;
                        x2  <= x2_n;
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_div_gen.sv
// Scoreboard bench for gf_div_gen: an 8-bit (p=251) and a 256-bit (secp256k1) instance share clock and reset.
module tb_gf_div_gen;
    import gf_pkg::*;

`ifdef GF_DIV_CT_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif
    localparam int L8   = 40;
    localparam int L256 = 1100;
    localparam logic [255:0] A256 =
        256'hAA5E28D6_A97A2479_A65527F7_290311A3_624D4CC0_FA157859_8EE3C261_3BF99521;

    typedef struct {
        logic [255:0] res;
        logic         err;
        int           lat;
        int           st;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         start8, mode8, busy8, done8, err8;
    logic [7:0]   p8, a8, b8, res8;
    logic         start256, mode256, busy256, done256, err256;
    logic [255:0] p256, a256, b256, res256;

    gf_div_gen #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode_select(mode8),
        .p(p8), .a(a8), .b(b8),
        .result_div(res8), .busy(busy8), .done(done8), .div_err(err8)
    );

    gf_div_gen #(.WIDTH(256)) dut256 (
        .clk(clk), .rst(rst), .start(start256), .mode_select(mode256),
        .p(p256), .a(a256), .b(b256),
        .result_div(res256), .busy(busy256), .done(done256), .div_err(err256)
    );

    exp_t q8[$];
    exp_t q256[$];
    exp_t m8, m256;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, expv);
        end
    endtask

    // Latency counts edges from the start edge up to the edge that first samples done high.
    function automatic int lat_of(input int vt, input int ct);
        return CT ? ct : vt;
    endfunction

    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL done8_unexpected: got done with result %0d, required no done", res8);
            end else begin
                m8 = q8.pop_front();
                check({m8.name, ".result"}, 256'(res8), m8.res);
                check({m8.name, ".div_err"}, 256'(err8), 256'(m8.err));
                if (m8.lat >= 0)
                    check({m8.name, ".latency"}, 256'(cyc - m8.st + 1), 256'(m8.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done256) begin
            if (q256.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL done256_unexpected: got done with result %0d, required no done", res256);
            end else begin
                m256 = q256.pop_front();
                check({m256.name, ".result"}, res256, m256.res);
                check({m256.name, ".div_err"}, 256'(err256), 256'(m256.err));
                if (m256.lat >= 0)
                    check({m256.name, ".latency"}, 256'(cyc - m256.st + 1), 256'(m256.lat));
            end
        end
    end

    task automatic issue8(input logic md, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] r, input logic e, input int lat,
                          input string nm, input bit expect_done);
        exp_t ex;
        @(negedge clk);
        mode8  = md;
        a8     = av;
        b8     = bv;
        start8 = 1'b1;
        if (expect_done) begin
            ex.res = 256'(r); ex.err = e; ex.lat = lat; ex.st = cyc + 1; ex.name = nm;
            q8.push_back(ex);
        end
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue256(input logic md, input logic [255:0] av, input logic [255:0] bv,
                            input logic [255:0] r, input logic e, input int lat, input string nm);
        exp_t ex;
        @(negedge clk);
        mode256  = md;
        a256     = av;
        b256     = bv;
        start256 = 1'b1;
        ex.res = r; ex.err = e; ex.lat = lat; ex.st = cyc + 1; ex.name = nm;
        q256.push_back(ex);
        @(negedge clk);
        start256 = 1'b0;
    endtask

    task automatic wait8(input string nm);
        int   k = 0;
        exp_t drop;
        while (!done8 && k < L8) begin
            @(negedge clk);
            k++;
        end
        if (!done8) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s.timeout: got no done in %0d cycles, required done", nm, k);
            if (q8.size() > 0) drop = q8.pop_front();
        end
    endtask

    task automatic wait256(input string nm);
        int   k = 0;
        exp_t drop;
        while (!done256 && k < L256) begin
            @(negedge clk);
            k++;
        end
        if (!done256) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s.timeout: got no done in %0d cycles, required done", nm, k);
            if (q256.size() > 0) drop = q256.pop_front();
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; p8 = 8'd251; a8 = 8'd0; b8 = 8'd0;
        start256 = 1'b0; mode256 = 1'b0; p256 = SECP256K1_P; a256 = '0; b256 = '0;
        repeat (3) @(negedge clk);
        check("rst.result8", 256'(res8), 256'd0);
        check("rst.busy8", 256'(busy8), 256'd0);
        check("rst.done8", 256'(done8), 256'd0);
        check("rst.err8", 256'(err8), 256'd0);
        check("rst.result256", res256, 256'd0);
        check("rst.busy256", 256'(busy256), 256'd0);
        check("rst.done256", 256'(done256), 256'd0);
        check("rst.err256", 256'(err256), 256'd0);
        rst = 1'b0;

        issue8(1'b1, 8'd0,   8'd2,   8'd126, 1'b0, lat_of(3, 34),  "inv_b2", 1'b1);      wait8("inv_b2");
        issue8(1'b0, 8'd3,   8'd2,   8'd127, 1'b0, lat_of(3, 34),  "div_3_2", 1'b1);     wait8("div_3_2");
        issue8(1'b0, 8'd0,   8'd5,   8'd0,   1'b0, lat_of(-1, 34), "div_0_5", 1'b1);     wait8("div_0_5");
        issue8(1'b1, 8'd0,   8'd1,   8'd1,   1'b0, lat_of(2, 34),  "inv_b1", 1'b1);      wait8("inv_b1");
        issue8(1'b1, 8'd0,   8'd250, 8'd250, 1'b0, lat_of(13, 34), "inv_b250", 1'b1);    wait8("inv_b250");
        issue8(1'b1, 8'd0,   8'd0,   8'd0,   1'b1, lat_of(1, 34),  "inv_b0", 1'b1);      wait8("inv_b0");
        issue8(1'b0, 8'd9,   8'd0,   8'd0,   1'b1, lat_of(1, 34),  "div_b0", 1'b1);      wait8("div_b0");
        issue8(1'b0, 8'd7,   8'd3,   8'd86,  1'b0, lat_of(-1, 34), "div_7_3", 1'b1);     wait8("div_7_3");
        issue8(1'b0, 8'd250, 8'd250, 8'd1,   1'b0, lat_of(-1, 34), "div_250_250", 1'b1); wait8("div_250_250");

        issue256(1'b0, A256, 256'd1, A256, 1'b0, lat_of(2, 1026), "p256_div_b1");
        wait256("p256_div_b1");
        issue256(1'b1, '0, SECP256K1_P - 256'd1, SECP256K1_P - 256'd1, 1'b0, lat_of(-1, 1026), "p256_inv_m1");
        wait256("p256_inv_m1");
        issue256(1'b0, A256, SECP256K1_P - 256'd1, SECP256K1_P - A256, 1'b0, lat_of(-1, 1026), "p256_div_m1");
        wait256("p256_div_m1");
        issue256(1'b1, '0, 256'd0, 256'd0, 1'b1, lat_of(1, 1026), "p256_inv_b0");
        wait256("p256_inv_b0");

        // A start pulse with different operands mid-run must not disturb the running operation.
        issue8(1'b1, 8'd0, 8'd250, 8'd250, 1'b0, lat_of(13, 34), "ignore_start", 1'b1);
        repeat (3) @(negedge clk);
        mode8 = 1'b0; a8 = 8'd7; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait8("ignore_start");
        repeat (3) @(negedge clk);
        check("hold.result8", 256'(res8), 256'd250);

        // Reset mid-run aborts without a done pulse.
        issue8(1'b1, 8'd0, 8'd250, 8'd0, 1'b0, -1, "rst_abort", 1'b0);
        repeat (3) @(negedge clk);
        check("abort.busy_before", 256'(busy8), 256'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort.result8", 256'(res8), 256'd0);
        check("abort.busy8", 256'(busy8), 256'd0);
        check("abort.done8", 256'(done8), 256'd0);
        check("abort.err8", 256'(err8), 256'd0);
        rst = 1'b0;
        repeat (L8) @(negedge clk);

        issue8(1'b1, 8'd0, 8'd3, 8'd84, 1'b0, lat_of(-1, 34), "inv_b3_after_rst", 1'b1);
        wait8("inv_b3_after_rst");
        repeat (3) @(negedge clk);
        check("q8.pending", 256'(q8.size()), 256'd0);
        check("q256.pending", 256'(q256.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gf_div_gen.md
GF_DIV_GEN -- requirements
Module: gf_div_gen

Interface
REQ-001 Parameter WIDTH, default 256, operand/modulus width in bits (min 8).
REQ-002 Parameter MAX_STEPS, default 4*WIDTH, iteration bound and constant-time cycle count.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request pulse, sampled only in IDLE.
REQ-006 mode_select  input  1  0 = division (a * b^-1 mod p), 1 = inversion (b^-1 mod p; a ignored).
REQ-007 p  input  WIDTH  odd modulus, p > 2; sampled with start.
REQ-008 a  input  WIDTH  dividend, a < p; sampled with start.
REQ-009 b  input  WIDTH  divisor, b < p; sampled with start.
REQ-010 result_div  output  WIDTH  quotient/inverse, held until the next accepted start.
REQ-011 busy  output  1  high while the operation is in progress (RUN).
REQ-012 done  output  1  one-cycle pulse: result_div and div_err valid.
REQ-013 div_err  output  1  b == 0 detected; valid with done, held with result_div.

Function
REQ-014 FSM states: IDLE, RUN, FIN; IDLE->RUN on start, RUN->FIN on termination, FIN->IDLE unconditionally.
REQ-015 On start in IDLE: u=b, v=p, x1=(mode_select ? 1 : a), x2=0, step counter=0; inputs are not re-sampled afterwards.
REQ-016 Each RUN cycle performs exactly one step, in priority: u even -> u>>=1, x1=halve(x1); else v even -> v>>=1, x2=halve(x2); else u>=v -> u-=v, x1=(x1-x2) mod p; else v-=u, x2=(x2-x1) mod p.
REQ-017 halve(x) = x>>1 if x even, else (x+p)>>1 computed at WIDTH+1 bits; the result is always < p.
REQ-018 Modular subtraction adds p when the difference is negative; the result is always in [0, p-1].
REQ-019 Termination: u==1 -> result x1; v==1 -> result x2 (u checked first); the result is registered on the transition to FIN.
REQ-020 b==0 at start: div_err=1, result_div=0, the step loop is skipped, done is asserted at the earliest legal cycle (or the constant-time cycle when CT is enabled).
REQ-021 Step counter reaching MAX_STEPS without termination: forced to FIN with div_err=1, result_div=0 (non-invertible guard).
REQ-022 done is high exactly in the FIN cycle; busy is high in RUN only; start is ignored in RUN and FIN.
REQ-023 Variable-time latency: done arrives at steps+2 cycles after the start edge, never more than MAX_STEPS+2.
REQ-024 Inputs violating a<p, b<p, p odd: result unspecified; done is still asserted within the bound.

Reset
REQ-025 rst high at a clock edge: state=IDLE, result_div=0, busy=0, done=0, div_err=0, internal registers cleared.
REQ-026 rst during RUN/FIN aborts the operation with no done pulse; rst has priority over start on the same edge.

Configuration
REQ-027 Macro GF_DIV_CT_EN defined: constant-time mode; after termination the FSM keeps stepping with dummy updates (state frozen) and done is asserted exactly MAX_STEPS+2 cycles after the start edge for every operand, including b==0.
REQ-028 GF_DIV_CT_EN undefined: variable-time behaviour per REQ-023; no dummy-cycle logic is synthesised.

Structure
REQ-029 Shared package gf_pkg holds the FSM state enum, the default WIDTH (256) and the secp256k1 prime constant.
REQ-030 One sub-module gf_half_mod (combinational modular halving, WIDTH-parametrised) is instantiated twice, for x1 and x2.

Verification
REQ-031 WIDTH=8, p=251, mode=1, b=2 -> done with result_div=126, div_err=0.
REQ-032 WIDTH=8, p=251, mode=0, a=3, b=2 -> result_div=127; a=0, b=5 -> result_div=0.
REQ-033 WIDTH=256, p=secp256k1 (FFFF...FFFEFFFFFC2F), mode=0, a=AA5E28D6...3BF99521, b=1 -> result_div=a; mode=1, b=p-1 -> result_div=p-1.
REQ-034 b=0, any mode -> done pulse, div_err=1, result_div=0; a subsequent valid op clears div_err.
REQ-035 rst asserted mid-RUN -> no done pulse, all outputs 0 next cycle; start pulses during RUN are ignored; with the op completing normally, result_div is unchanged.
REQ-036 GF_DIV_CT_EN build, WIDTH=8 -> done exactly 34 cycles after the start edge for b=1, b=2, b=250 and b=0.
